// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and helpers for the tx_arbiter slice.
// Holds the FSM state enum, the data word width and the rotation helper.
package tx_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFFER    = 2'd1,
    WAIT_LOW = 2'd2
  } tx_state_e;

  function automatic int rr_idx(input int base, input int off,
                                input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
// Search begins one past last_grant and wraps at NUM_REQ.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic           found;
  logic [IDW-1:0] p;

  // first valid requester after last_grant wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    p         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      p = IDW'(rr_idx(int'(last_grant), k, NUM_REQ));
      if (!found && req_valid[p]) begin
        found     = 1'b1;
        grant[p]  = 1'b1;
        grant_idx = p;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin feeder for a tclk-side handshake transmitter.
// Define TX_ARB_TIMEOUT_EN to enable the OFFER watchdog.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       tclk,
  input  logic                       resetb_tclk,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  input  logic                       t_rdy,
  output logic                       data_avail,
  output logic [DATA_W-1:0]          transmit_data,
  output logic [$clog2(NUM_REQ)-1:0] cur_id,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int IDW = $clog2(NUM_REQ);

  tx_state_e          state_q, state_d;
  logic               avail_q, avail_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0] oh_q, oh_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDW-1:0]     pick_idx;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic           err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_q),
    .grant      (pick_oh),
    .grant_idx  (pick_idx)
  );

  // next-state and output decode for the offer handshake
  always_comb begin
    state_d = state_q;
    avail_d = avail_q;
    data_d  = data_q;
    ack_d   = '0;
    id_d    = id_q;
    oh_d    = oh_q;
    last_d  = last_q;
`ifdef TX_ARB_TIMEOUT_EN
    err_d   = 1'b0;
    wd_d    = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = OFFER;
          avail_d = 1'b1;
          data_d  = req_data[DATA_W*pick_idx +: DATA_W];
          id_d    = pick_idx;
          oh_d    = pick_oh;
        end
      end
      OFFER: begin
        if (t_rdy) begin
          state_d = WAIT_LOW;
          avail_d = 1'b0;
          ack_d   = oh_q;
          last_d  = id_q;
`ifdef TX_ARB_TIMEOUT_EN
        end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          avail_d = 1'b0;
          err_d   = 1'b1;
          last_d  = id_q;
        end else begin
          wd_d    = wd_q + 1'b1;
`endif
        end
      end
      WAIT_LOW: begin
        if (!t_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge tclk or negedge resetb_tclk) begin
    if (!resetb_tclk) begin
      state_q <= IDLE;
      avail_q <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      id_q    <= '0;
      oh_q    <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      avail_q <= avail_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      id_q    <= id_d;
      oh_q    <= oh_d;
      last_q  <= last_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  // watchdog counter and its error pulse
  always_ff @(posedge tclk or negedge resetb_tclk) begin
    if (!resetb_tclk) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign data_avail    = avail_q;
  assign transmit_data = data_q;
  assign req_ack       = ack_q;
  assign cur_id        = id_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed + random checks of tx_arbiter against a model.
// Honours TX_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8.
module tb_tx_arbiter;

  localparam int NR  = 4;
  localparam int TOC = 8;
`ifdef TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             tclk = 1'b0;
  logic             resetb_tclk = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*32-1:0] req_data = '0;
  logic [NR-1:0]    req_ack;
  logic             t_rdy = 1'b0;
  logic             data_avail;
  logic [31:0]      transmit_data;
  logic [1:0]       cur_id;
  logic             busy;
  logic             err_timeout;

  always #5 tclk = ~tclk;

  tx_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .tclk          (tclk),
    .resetb_tclk   (resetb_tclk),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .t_rdy         (t_rdy),
    .data_avail    (data_avail),
    .transmit_data (transmit_data),
    .cur_id        (cur_id),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: transfer phase 0=no transfer, 1=word offered,
  // 2=accepted and waiting for the transmitter to drop ready
  int          m_st;
  bit          m_av;
  logic [31:0] m_data;
  int          m_id;
  logic [NR-1:0] m_ack;
  int          m_last;
  bit          m_err;
  int          m_wd;

  task automatic model_reset();
    m_st = 0; m_av = 0; m_data = '0; m_id = 0;
    m_ack = '0; m_last = NR - 1; m_err = 0; m_wd = 0;
  endtask

  task automatic model_edge(input logic [NR-1:0] v,
                            input logic [NR*32-1:0] d, input logic tr);
    int p;
    p = 0;
    m_ack = '0;
    m_err = 0;
    if (m_st == 0) begin
      if (v != '0) begin
        for (int k = 1; k <= NR; k++) begin
          p = (m_last + k) % NR;
          if (v[p]) break;
        end
        m_st = 1; m_av = 1; m_id = p; m_wd = 0;
        m_data = d[32*p +: 32];
      end
    end else if (m_st == 1) begin
      if (tr) begin
        m_st = 2; m_av = 0; m_ack[m_id] = 1'b1; m_last = m_id;
      end else if (TO_EN) begin
        m_wd++;
        if (m_wd >= TOC) begin
          m_st = 0; m_av = 0; m_err = 1; m_last = m_id;
        end
      end
    end else if (!tr) begin
      m_st = 0;
    end
  endtask

  function automatic logic [NR*32-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // drive one cycle from a negedge, advance model, compare
  task automatic cycle(input logic [NR-1:0] v,
                       input logic [NR*32-1:0] d, input logic tr);
    req_valid = v; req_data = d; t_rdy = tr;
    @(posedge tclk);
    model_edge(v, d, tr);
    #1;
    check("data_avail", 64'(data_avail), 64'(m_av));
    check("transmit_data", 64'(transmit_data), 64'(m_data));
    check("cur_id", 64'(cur_id), 64'(m_id));
    check("req_ack", 64'(req_ack), 64'(m_ack));
    check("busy", 64'(busy), 64'(m_st != 0));
    check("err_timeout", 64'(err_timeout), 64'(m_err));
    @(negedge tclk);
  endtask

  task automatic do_reset();
    resetb_tclk = 1'b0;
    #1;
    check("rst_avail", 64'(data_avail), 64'd0);
    check("rst_data", 64'(transmit_data), 64'd0);
    check("rst_ack", 64'(req_ack), 64'd0);
    check("rst_id", 64'(cur_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    repeat (2) @(posedge tclk);
    model_reset();
    @(negedge tclk);
    req_valid = '0; t_rdy = 1'b0;
    resetb_tclk = 1'b1;
  endtask

  logic [NR*32-1:0] d;
  logic tr;
  int   q[$];
  int   n3;

  initial begin
    model_reset();
    @(negedge tclk);
    do_reset();

    // single request from requester 2
    d = rnd_data();
    d[64 +: 32] = 32'hDEADBEEF;
    cycle(4'b0100, d, 1'b0);
    check("single_avail", 64'(data_avail), 64'd1);
    check("single_data", 64'(transmit_data), 64'hDEADBEEF);
    check("single_id", 64'(cur_id), 64'd2);
    cycle(4'b0100, rnd_data(), 1'b1);
    check("single_ack", 64'(req_ack), 64'b0100);
    check("single_drop", 64'(data_avail), 64'd0);
    cycle(4'b0000, rnd_data(), 1'b0);
    check("single_ack_pulse", 64'(req_ack), 64'd0);

    // rotation with all requesters continuously valid
    do_reset();
    tr = 1'b0;
    q.delete();
    for (int i = 0; i < 60 && q.size() < 5; i++) begin
      tr = m_av;
      cycle(4'b1111, rnd_data(), tr);
      for (int k = 0; k < NR; k++)
        if (req_ack[k]) q.push_back(k);
    end
    check("rot_count", 64'(q.size()), 64'd5);
    for (int i = 0; i < 5 && i < q.size(); i++)
      check($sformatf("rot_%0d", i), 64'(q[i]), 64'(i % NR));

    // WAIT_LOW hold with requester 1 pending
    do_reset();
    cycle(4'b0010, rnd_data(), 1'b0);
    cycle(4'b0010, rnd_data(), 1'b1);
    check("hold_ack", 64'(req_ack), 64'b0010);
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0010, rnd_data(), 1'b1);
      check($sformatf("hold_%0d", i), 64'(data_avail), 64'd0);
    end
    cycle(4'b0010, rnd_data(), 1'b0);
    check("hold_low_seen", 64'(data_avail), 64'd0);
    cycle(4'b0010, rnd_data(), 1'b0);
    check("hold_reoffer", 64'(data_avail), 64'd1);
    check("hold_reoffer_id", 64'(cur_id), 64'd1);

    // withdrawal of requester 3 during OFFER
    do_reset();
    n3 = 0;
    cycle(4'b1000, rnd_data(), 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(4'b0000, rnd_data(), i == 2);
      if (req_ack[3]) n3++;
    end
    check("withdraw_acks", 64'(n3), 64'd1);

    // reset while offering, then 0 and 3 compete
    do_reset();
    cycle(4'b0100, rnd_data(), 1'b0);
    check("mid_offer", 64'(data_avail), 64'd1);
    do_reset();
    cycle(4'b1001, rnd_data(), 1'b0);
    check("post_rst_id", 64'(cur_id), 64'd0);

`ifdef TX_ARB_TIMEOUT_EN
    // watchdog expiry with the transmitter stuck not-ready
    do_reset();
    cycle(4'b0001, rnd_data(), 1'b0);
    for (int i = 0; i < TOC - 1; i++) begin
      cycle(4'b0001, rnd_data(), 1'b0);
      check($sformatf("to_wait_%0d", i), 64'(data_avail), 64'd1);
    end
    cycle(4'b0001, rnd_data(), 1'b0);
    check("to_err", 64'(err_timeout), 64'd1);
    check("to_avail", 64'(data_avail), 64'd0);
    check("to_noack", 64'(req_ack), 64'd0);
    cycle(4'b0011, rnd_data(), 1'b0);
    check("to_next_id", 64'(cur_id), 64'd1);
    check("to_err_pulse", 64'(err_timeout), 64'd0);
`endif

    // random traffic with a transmitter-like ready
    do_reset();
    tr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        tr = 1'b0;
      end
      if (m_av && !tr && $urandom_range(0, 2) == 0) tr = 1'b1;
      else if (tr && !m_av && $urandom_range(0, 1) == 0) tr = 1'b0;
      cycle(($urandom_range(0, 3) == 0) ? 4'b0000
                                        : 4'($urandom_range(0, 15)),
            rnd_data(), tr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in tclk cycles (used only with TX_ARB_TIMEOUT_EN).
REQ-003 SHALL have port tclk, input, 1, the single clock.
REQ-004 SHALL have port resetb_tclk, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester request.
REQ-006 SHALL have port req_data, input, NUM_REQ*32, flattened per-requester words; requester i occupies bits [32*i+31:32*i].
REQ-007 SHALL have port req_ack, output, NUM_REQ, one-cycle acceptance pulse per requester.
REQ-008 SHALL have port t_rdy, input, 1, ready flag from the tclk-side handshake transmitter.
REQ-009 SHALL have port data_avail, output, 1, offer to the handshake transmitter.
REQ-010 SHALL have port transmit_data, output, 32, word offered to the handshake transmitter.
REQ-011 SHALL have port cur_id, output, $clog2(NUM_REQ), index of the requester being served.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port err_timeout, output, 1, one-cycle watchdog pulse.

Function
REQ-014 SHALL implement the states IDLE, OFFER and WAIT_LOW.
REQ-015 SHALL, in IDLE with any req_valid bit high, pick a winner by round-robin (search starts at last_grant+1, wraps at NUM_REQ), latch its index into cur_id and its word into transmit_data, and enter OFFER with data_avail=1 on the next cycle.
REQ-016 SHALL hold data_avail=1 and transmit_data stable throughout OFFER.
REQ-017 SHALL, in OFFER on sampling t_rdy=1, drive data_avail=0, pulse req_ack[cur_id] for exactly one cycle, set last_grant=cur_id, and enter WAIT_LOW, all on the next cycle.
REQ-018 SHALL, in WAIT_LOW on sampling t_rdy=0, return to IDLE, with no new offer made while t_rdy is high.
REQ-019 SHALL have a minimum request-to-data_avail latency of 1 cycle.
REQ-020 SHALL leave an in-flight transfer unaffected if req_valid drops during OFFER; req_data changes after the IDLE latch are ignored.
REQ-021 SHALL grant requester 0 first on simultaneous requests after reset, and rotate strictly when all requesters are continuously valid (0,1,2,3,0,...).
REQ-022 SHALL keep transmit_data at its last value outside OFFER, with req_ack all-zero except the pulse required by REQ-017.

Reset
REQ-023 SHALL, on resetb_tclk=0, immediately force state=IDLE, data_avail=0, transmit_data=0, req_ack=0, cur_id=0, busy=0, err_timeout=0, last_grant=NUM_REQ-1 and watchdog=0.
REQ-024 SHALL abandon any in-flight transfer on reset mid-operation, with no req_ack issued for it.

Configuration
REQ-025 SHALL, with macro TX_ARB_TIMEOUT_EN defined, count cycles spent in OFFER; on reaching TIMEOUT_CYCLES with t_rdy still 0, drop data_avail, pulse err_timeout for one cycle, set last_grant=cur_id, issue no req_ack, and return to IDLE.
REQ-026 SHALL, with TX_ARB_TIMEOUT_EN undefined, exclude the counter, tie err_timeout to 0, and wait indefinitely in OFFER.

Structure
REQ-027 SHALL place the state enum (IDLE, OFFER, WAIT_LOW) and DATA_W=32 in package tx_arb_pkg.
REQ-028 SHALL implement winner selection in sub-module rr_pick, which takes req_valid and last_grant and returns a one-hot grant plus index and is purely combinational.

Verification
REQ-029 SHALL verify single request: req_valid=4'b0100 with data 0xDEAD_BEEF -> data_avail=1 next cycle, transmit_data=0xDEADBEEF, cur_id=2; t_rdy=1 -> req_ack=4'b0100 pulse, data_avail=0.
REQ-030 SHALL verify rotation: all four valid continuously with t_rdy mimicking the handshake -> grant order 0,1,2,3,0.
REQ-031 SHALL verify the WAIT_LOW hold: t_rdy held high 10 cycles after ack with req 1 pending -> data_avail stays 0 until 1 cycle after t_rdy=0 is sampled.
REQ-032 SHALL verify request withdrawal: req_valid[3] dropped during OFFER -> offer completes and req_ack[3] pulses once.
REQ-033 SHALL verify mid-transfer reset: resetb_tclk=0 in OFFER -> all outputs 0 asynchronously; after release with req 0 and req 3 valid, requester 0 is granted.
REQ-034 SHALL verify the timeout (TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): t_rdy stuck at 0 -> err_timeout pulses after 8 OFFER cycles, no req_ack, next grant goes to the next requester.
